// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, register file shape,
// load funct3 encodings and the load alignment rule.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic ld_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off != 2'd0);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB latch outputs, decode read ports and writeback
// status bundled as one port group.
interface wb_regfile_if
  import rv32_pkg::*;
#(
  parameter int CNT_W = 64
);

  logic             memwb_RegW;
  logic             memToReg;
  logic [XLEN-1:0]  memwb_MemData;
  logic [XLEN-1:0]  memwb_ExData;
  logic [4:0]       memwb_RegRd;
  logic [2:0]       memwb_Funct3;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic [CNT_W-1:0] wb_count;
  logic             misalign_err;

  modport master (
    output memwb_RegW, memToReg, memwb_MemData,
    output memwb_ExData, memwb_RegRd, memwb_Funct3,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_we,
    input  wb_count, misalign_err
  );

  modport slave (
    input  memwb_RegW, memToReg, memwb_MemData,
    input  memwb_ExData, memwb_RegRd, memwb_Funct3,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_we,
    output wb_count, misalign_err
  );

endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a loaded word
// and sign- or zero-extends it by load type.
module load_extend
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // unknown load types fall back to a full word
  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file with write bypass,
// retired-write counter and sticky misaligned-load flag.
module wb_regfile
  import rv32_pkg::*;
#(
  parameter int CNT_W = 64
)
(
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0]  ld_ext;
  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic             mis_hit;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mis_q;
  logic             mis_d;
  logic [XLEN-1:0]  rs1_v;
  logic [XLEN-1:0]  rs2_v;

  load_extend u_ext (
    .word_i   (bus.memwb_MemData),
    .funct3_i (bus.memwb_Funct3),
    .off_i    (bus.memwb_ExData[1:0]),
    .data_o   (ld_ext)
  );

  assign wb_data = bus.memToReg ? ld_ext
                                : bus.memwb_ExData;
  assign wb_we   = bus.memwb_RegW &&
                   (bus.memwb_RegRd != REG_ZERO);
  assign mis_hit = bus.memwb_RegW && bus.memToReg &&
                   ld_misaligned(bus.memwb_Funct3,
                                 bus.memwb_ExData[1:0]);

  assign cnt_d = wb_we ? cnt_q + CNT_W'(1) : cnt_q;
  assign mis_d = mis_q | mis_hit;

  // x0 slot is never written, so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[bus.memwb_RegRd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  always_comb begin
    rs1_v = '0;
    if (bus.rs1_addr != REG_ZERO) begin
      if (wb_we && bus.rs1_addr == bus.memwb_RegRd)
        rs1_v = wb_data;
      else
        rs1_v = regs_q[bus.rs1_addr];
    end
  end

  always_comb begin
    rs2_v = '0;
    if (bus.rs2_addr != REG_ZERO) begin
      if (wb_we && bus.rs2_addr == bus.memwb_RegRd)
        rs2_v = wb_data;
      else
        rs2_v = regs_q[bus.rs2_addr];
    end
  end

  assign bus.rs1_data     = rs1_v;
  assign bus.rs2_data     = rs2_v;
  assign bus.wb_data      = wb_data;
  assign bus.wb_we        = wb_we;
  assign bus.wb_count     = cnt_q;
  assign bus.misalign_err = mis_q;

endmodule
